// File: rtl/sound_pkg.sv
// Shared types and defaults for the sound event controller.
package sound_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } snd_state_t;

  localparam int unsigned SND_GAP_CYC = 2;

endpackage

// File: rtl/sound_edge_det.sv
// Per-bit rising-edge detector: rise is high in the cycle where d goes 0 -> 1.
module sound_edge_det #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] r_prev;

  // Remember the level sampled at the previous edge.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_prev <= '0;
    else       r_prev <= d;
  end

  // Rise seen at this edge: high now, low at the previous edge.
  always_comb begin
    rise = d & ~r_prev;
  end

endmodule

// File: rtl/sound_event_ctrl.sv
// Multi-channel sound event controller: edge-detects events, keeps one pending
// request per channel, plays by fixed priority with preemption, and supports mute.
module sound_event_ctrl
  import sound_pkg::*;
#(
  parameter int unsigned N_EVT   = 4,
  parameter int unsigned TONE_W  = 8,
  parameter int unsigned DUR_W   = 16,
  parameter int unsigned GAP_CYC = SND_GAP_CYC
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic                       button,
  input  logic [N_EVT-1:0]           evt_i,
  input  logic [N_EVT*TONE_W-1:0]    tone_tbl_i,
  input  logic [N_EVT*DUR_W-1:0]     dur_tbl_i,
  output logic                       playSound,
  output logic [TONE_W-1:0]          tone_o,
  output logic [$clog2(N_EVT)-1:0]   chan_o,
  output mode_t                      mode_o,
  output logic                       busy_o
);

  localparam int unsigned CH_W = $clog2(N_EVT);

  snd_state_t        r_state, w_state_nxt;
  logic [DUR_W-1:0]  r_cnt, w_cnt_nxt;
  logic [N_EVT-1:0]  r_pend, w_pend_nxt;
  mode_t             w_mode_nxt;
  logic              w_play_nxt;
  logic [TONE_W-1:0] w_tone_nxt;
  logic [CH_W-1:0]   w_chan_nxt;
  logic              w_busy_nxt;

  logic [N_EVT-1:0]  w_evt_rise;
  logic [0:0]        w_btn_rise;
  logic              w_any;
  logic [CH_W-1:0]   w_pick;
  logic              w_load;
  logic              w_mute;
  logic [N_EVT-1:0]  w_clr;
  logic [DUR_W-1:0]  w_dur_sel;

  // Lowest set index wins.
  function automatic logic [CH_W-1:0] f_pick(input logic [N_EVT-1:0] v);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = N_EVT - 1; i >= 0; i--) begin
      if (v[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  sound_edge_det #(.W(N_EVT)) u_evt_edge (
    .clk  (clk),
    .nRst (nRst),
    .d    (evt_i),
    .rise (w_evt_rise)
  );

  sound_edge_det #(.W(1)) u_btn_edge (
    .clk  (clk),
    .nRst (nRst),
    .d    (button),
    .rise (w_btn_rise)
  );

  // Next state, counter, pending set and output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_play_nxt  = playSound;
    w_tone_nxt  = tone_o;
    w_chan_nxt  = chan_o;
    w_load      = 1'b0;
    w_clr       = '0;

    w_mode_nxt = mode_t'(mode_o ^ w_btn_rise[0]);
    w_mute     = (w_mode_nxt == OFF);
    w_any      = |r_pend;
    w_pick     = f_pick(r_pend);
    w_dur_sel  = dur_tbl_i[int'(w_pick)*DUR_W +: DUR_W];

    case (r_state)
      IDLE: begin
        if (mode_o == ON && w_any) w_load = 1'b1;
      end
      PLAY: begin
        if (w_any && (w_pick < chan_o)) begin
          w_load = 1'b1;
        end else if (r_cnt == DUR_W'(1)) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = DUR_W'(GAP_CYC);
          w_play_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - DUR_W'(1);
        end
      end
      GAP: begin
        if (r_cnt <= DUR_W'(1)) w_state_nxt = IDLE;
        else                    w_cnt_nxt   = r_cnt - DUR_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase

    // A load is suppressed when mute takes effect at the same edge.
    if (w_load && !w_mute) begin
      w_state_nxt = PLAY;
      w_cnt_nxt   = (w_dur_sel == '0) ? DUR_W'(1) : w_dur_sel;
      w_tone_nxt  = tone_tbl_i[int'(w_pick)*TONE_W +: TONE_W];
      w_chan_nxt  = w_pick;
      w_play_nxt  = 1'b1;
      w_clr       = N_EVT'(1) << w_pick;
    end

    w_pend_nxt = (r_pend & ~w_clr) | w_evt_rise;

    if (w_mute) begin
      w_pend_nxt  = '0;
      w_play_nxt  = 1'b0;
      w_state_nxt = IDLE;
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State, counter, pending set and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      mode_o    <= ON;
      playSound <= 1'b0;
      tone_o    <= '0;
      chan_o    <= '0;
      busy_o    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      mode_o    <= w_mode_nxt;
      playSound <= w_play_nxt;
      tone_o    <= w_tone_nxt;
      chan_o    <= w_chan_nxt;
      busy_o    <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_sound_event_ctrl.sv
// Directed bench for sound_event_ctrl: vector table plus hand-written corner sequences.
module tb_sound_event_ctrl;

  logic        clk;
  logic        nRst;
  logic        button;
  logic [3:0]  evt_i;
  logic [31:0] tone_tbl_i;
  logic [63:0] dur_tbl_i;
  logic        playSound;
  logic [7:0]  tone_o;
  logic [1:0]  chan_o;
  logic        mode_o;
  logic        busy_o;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [3:0] evt;
    logic       btn;
    logic       play;
    logic [7:0] tone;
    logic [1:0] chan;
    logic       mode;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  sound_event_ctrl #(
    .N_EVT   (4),
    .TONE_W  (8),
    .DUR_W   (16),
    .GAP_CYC (2)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .button     (button),
    .evt_i      (evt_i),
    .tone_tbl_i (tone_tbl_i),
    .dur_tbl_i  (dur_tbl_i),
    .playSound  (playSound),
    .tone_o     (tone_o),
    .chan_o     (chan_o),
    .mode_o     (mode_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_n(input int n, input logic [3:0] evt, input logic btn, input logic play,
                       input logic [7:0] tone, input logic [1:0] chan, input logic mode,
                       input logic busy);
    vec_t v;
    v.evt = evt; v.btn = btn; v.play = play; v.tone = tone;
    v.chan = chan; v.mode = mode; v.busy = busy;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    nRst       = 1'b1;
    button     = 1'b0;
    evt_i      = 4'b0000;
    tone_tbl_i = {8'd10, 8'd20, 8'd30, 8'd40};
    dur_tbl_i  = {16'd10, 16'd0, 16'd3, 16'd4};

    // Reset before the first edge
    #2 nRst = 1'b0;
    #1;
    chk("rst_mode", 32'(mode_o), 32'd1);
    chk("rst_play", 32'(playSound), 32'd0);
    chk("rst_tone", 32'(tone_o), 32'd0);
    chk("rst_chan", 32'(chan_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    #9 nRst = 1'b1;

    // evt, btn, play, tone, chan, mode, busy
    // single event on channel 1
    add_n(1, 4'b0010, 0, 0,  0, 0, 1, 0);
    add_n(3, 4'b0000, 0, 1, 30, 1, 1, 1);
    add_n(2, 4'b0000, 0, 0, 30, 1, 1, 1);
    add_n(1, 4'b0000, 0, 0, 30, 1, 1, 0);
    // channels 0 and 3 together: 0 first, then 3
    add_n(1, 4'b1001, 0, 0, 30, 1, 1, 0);
    add_n(4, 4'b0000, 0, 1, 40, 0, 1, 1);
    add_n(2, 4'b0000, 0, 0, 40, 0, 1, 1);
    add_n(1, 4'b0000, 0, 0, 40, 0, 1, 0);
    add_n(10, 4'b0000, 0, 1, 10, 3, 1, 1);
    add_n(2, 4'b0000, 0, 0, 10, 3, 1, 1);
    add_n(1, 4'b0000, 0, 0, 10, 3, 1, 0);
    // mute, events ignored, unmute, no stale request
    add_n(1, 4'b0000, 1, 0, 10, 3, 0, 0);
    add_n(1, 4'b0010, 0, 0, 10, 3, 0, 0);
    add_n(1, 4'b0000, 0, 0, 10, 3, 0, 0);
    add_n(1, 4'b0010, 0, 0, 10, 3, 0, 0);
    add_n(3, 4'b0000, 0, 0, 10, 3, 0, 0);
    add_n(1, 4'b0000, 1, 0, 10, 3, 1, 0);
    add_n(2, 4'b0000, 0, 0, 10, 3, 1, 0);
    add_n(1, 4'b0010, 0, 0, 10, 3, 1, 0);
    add_n(3, 4'b0000, 0, 1, 30, 1, 1, 1);
    add_n(2, 4'b0000, 0, 0, 30, 1, 1, 1);
    add_n(1, 4'b0000, 0, 0, 30, 1, 1, 0);
    // button going OFF with event: discarded; going ON with event: pended
    add_n(1, 4'b0010, 1, 0, 30, 1, 0, 0);
    add_n(2, 4'b0000, 0, 0, 30, 1, 0, 0);
    add_n(1, 4'b0010, 1, 0, 30, 1, 1, 0);
    add_n(3, 4'b0000, 0, 1, 30, 1, 1, 1);
    add_n(2, 4'b0000, 0, 0, 30, 1, 1, 1);
    add_n(1, 4'b0000, 0, 0, 30, 1, 1, 0);
    // channel 2 held high: one tone, one cycle long
    add_n(1, 4'b0100, 0, 0, 30, 1, 1, 0);
    add_n(1, 4'b0100, 0, 1, 20, 2, 1, 1);
    add_n(2, 4'b0100, 0, 0, 20, 2, 1, 1);
    add_n(16, 4'b0100, 0, 0, 20, 2, 1, 0);
    add_n(1, 4'b0000, 0, 0, 20, 2, 1, 0);
    // retrigger channel 1 during its own tone
    add_n(1, 4'b0010, 0, 0, 20, 2, 1, 0);
    add_n(1, 4'b0000, 0, 1, 30, 1, 1, 1);
    add_n(1, 4'b0010, 0, 1, 30, 1, 1, 1);
    add_n(1, 4'b0000, 0, 1, 30, 1, 1, 1);
    add_n(2, 4'b0000, 0, 0, 30, 1, 1, 1);
    add_n(1, 4'b0000, 0, 0, 30, 1, 1, 0);
    add_n(3, 4'b0000, 0, 1, 30, 1, 1, 1);
    add_n(2, 4'b0000, 0, 0, 30, 1, 1, 1);
    add_n(1, 4'b0000, 0, 0, 30, 1, 1, 0);

    foreach (vq[i]) begin
      evt_i  = vq[i].evt;
      button = vq[i].btn;
      tick();
      chk($sformatf("v%0d_play", i), 32'(playSound), 32'(vq[i].play));
      chk($sformatf("v%0d_tone", i), 32'(tone_o),    32'(vq[i].tone));
      chk($sformatf("v%0d_chan", i), 32'(chan_o),    32'(vq[i].chan));
      chk($sformatf("v%0d_mode", i), 32'(mode_o),    32'(vq[i].mode));
      chk($sformatf("v%0d_busy", i), 32'(busy_o),    32'(vq[i].busy));
    end
    evt_i  = 4'b0000;
    button = 1'b0;

    // Preempt: channel 0 rises in the 4th cycle of channel 3
    evt_i = 4'b1000;
    tick();
    chk("pre_pend_play", 32'(playSound), 32'd0);
    evt_i = 4'b0000;
    tick();
    chk("pre_c3_play", 32'(playSound), 32'd1);
    chk("pre_c3_tone", 32'(tone_o), 32'd10);
    chk("pre_c3_chan", 32'(chan_o), 32'd3);
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) evt_i = 4'b0001;
      tick();
      chk($sformatf("pre_c3_cyc%0d_play", c), 32'(playSound), 32'd1);
      chk($sformatf("pre_c3_cyc%0d_tone", c), 32'(tone_o), 32'd10);
    end
    evt_i = 4'b0000;
    tick();
    chk("pre_c0_tone", 32'(tone_o), 32'd40);
    chk("pre_c0_chan", 32'(chan_o), 32'd0);
    chk("pre_c0_play", 32'(playSound), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("pre_c0_cyc%0d_play", c), 32'(playSound), 32'd1);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("pre_gap%0d_play", c), 32'(playSound), 32'd0);
      chk($sformatf("pre_gap%0d_busy", c), 32'(busy_o), 32'd1);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      chk($sformatf("pre_noresume%0d_busy", c), 32'(busy_o), 32'd0);
      chk($sformatf("pre_noresume%0d_chan", c), 32'(chan_o), 32'd0);
    end

    // Asynchronous reset in the middle of a tone
    evt_i = 4'b0010;
    tick();
    evt_i = 4'b0000;
    tick();
    chk("mid_play_before", 32'(playSound), 32'd1);
    tick();
    #3 nRst = 1'b0;
    #1;
    chk("mid_rst_play", 32'(playSound), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_tone", 32'(tone_o), 32'd0);
    chk("mid_rst_chan", 32'(chan_o), 32'd0);
    chk("mid_rst_mode", 32'(mode_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
